ysyx_25030081_ifu: RTL and testbench



---
 rtl/ysyx_25030081_ifu.sv | 103 ++++++++++
 tb/tb_ysyx_25030081_ifu.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25030081_ifu.sv
// Instruction fetch unit: owns the PC, issues one imem read at a time and holds the fetched word for decode.
// Optional performance counters are built when YSYX_25030081_IFU_PERF_EN is defined.
module ysyx_25030081_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef YSYX_25030081_IFU_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] req_addr;
  logic        drop;
  logic        resp_keep;
  logic        resp_discard;

  assign resp_keep      = (state == WAIT) && imem_resp_valid && !drop && !redirect_valid;
  assign resp_discard   = (state == WAIT) && imem_resp_valid && (drop || redirect_valid);

  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = req_addr;
  assign inst_valid     = (state == HOLD);

  // A redirect always wins over the sequential increment taken on a kept response.
  always_comb begin
    pc_next = pc;
    if (resp_keep) pc_next = pc + 32'd4;
    if (redirect_valid) pc_next = redirect_pc & 32'hFFFF_FFFC;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = REQ;
      REQ:  if (imem_req_ready) state_next = WAIT;
      WAIT: begin
        if (resp_discard) state_next = REQ;
        else if (resp_keep) state_next = HOLD;
      end
      HOLD: if (inst_ready || redirect_valid) state_next = REQ;
      default: state_next = IDLE;
    endcase
  end

  // The request address is captured on entry to REQ so it stays stable until accepted,
  // even if a redirect moves pc while the request is still pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      drop     <= 1'b0;
      inst     <= 32'h0000_0013;
      inst_pc  <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if ((state_next == REQ) && (state != REQ)) req_addr <= pc_next;
      if ((state == WAIT) && imem_resp_valid) drop <= 1'b0;
      else if (redirect_valid && ((state == REQ) || (state == WAIT))) drop <= 1'b1;
      if (resp_keep) begin
        inst    <= imem_resp_data;
        inst_pc <= pc;
      end
    end
  end

`ifdef YSYX_25030081_IFU_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= 32'd0;
      perf_stall_cnt <= 32'd0;
    end else begin
      if (inst_valid && inst_ready) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if ((state == REQ) || (state == WAIT)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_25030081_ifu.sv
// Testbench for ysyx_25030081_ifu: cycle-by-cycle vector table plus reset and multi-fetch sequences.
// Perf counter checks are compiled when YSYX_25030081_IFU_PERF_EN is defined.
module tb_ysyx_25030081_ifu;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef YSYX_25030081_IFU_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int n_compared = 0;
  int n_mismatched = 0;

  ysyx_25030081_ifu dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
`ifdef YSYX_25030081_IFU_PERF_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_stall_cnt  (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rq_rdy;
    logic        rs_v;
    logic [31:0] rs_d;
    logic        i_rdy;
    logic        rd_v;
    logic [31:0] rd_pc;
    logic        e_qv;
    logic [31:0] e_qa;
    logic        e_iv;
    logic [31:0] e_i;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t vecs[$];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic qv, input logic [31:0] qa,
                           input logic iv, input logic [31:0] i, input logic [31:0] ipc);
    check_output({tag, ".req_valid"}, {31'd0, imem_req_valid}, {31'd0, qv});
    check_output({tag, ".req_addr"}, imem_req_addr, qa);
    check_output({tag, ".inst_valid"}, {31'd0, inst_valid}, {31'd0, iv});
    check_output({tag, ".inst"}, inst, i);
    check_output({tag, ".inst_pc"}, inst_pc, ipc);
  endtask

  task automatic apply_stimulus(input vec_t v);
    imem_req_ready  = v.rq_rdy;
    imem_resp_valid = v.rs_v;
    imem_resp_data  = v.rs_d;
    inst_ready      = v.i_rdy;
    redirect_valid  = v.rd_v;
    redirect_pc     = v.rd_pc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    inst_ready      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
  endtask

  initial begin
    // rq_rdy rs_v rs_d          i_rdy rd_v rd_pc        | qv qa            iv inst          inst_pc
    vecs.push_back('{1'b1, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0,          1'b1, 32'h8000_0000, 1'b0, 32'h0000_0013, 32'h8000_0000});
    vecs.push_back('{1'b1, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0,          1'b0, 32'h8000_0000, 1'b0, 32'h0000_0013, 32'h8000_0000});
    vecs.push_back('{1'b0, 1'b1, 32'h0010_0093,  1'b1, 1'b0, 32'h0,          1'b0, 32'h8000_0000, 1'b1, 32'h0010_0093, 32'h8000_0000});
    vecs.push_back('{1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 32'h0,          1'b1, 32'h8000_0004, 1'b0, 32'h0010_0093, 32'h8000_0000});
    for (int k = 0; k < 4; k++)
      vecs.push_back('{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,          1'b1, 32'h8000_0004, 1'b0, 32'h0010_0093, 32'h8000_0000});
    vecs.push_back('{1'b1, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0,          1'b0, 32'h8000_0004, 1'b0, 32'h0010_0093, 32'h8000_0000});
    vecs.push_back('{1'b0, 1'b1, 32'h0020_0113,  1'b0, 1'b0, 32'h0,          1'b0, 32'h8000_0004, 1'b1, 32'h0020_0113, 32'h8000_0004});
    for (int k = 0; k < 3; k++)
      vecs.push_back('{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,          1'b0, 32'h8000_0004, 1'b1, 32'h0020_0113, 32'h8000_0004});
    vecs.push_back('{1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 32'h0,          1'b1, 32'h8000_0008, 1'b0, 32'h0020_0113, 32'h8000_0004});
    // Redirect in WAIT before the response arrives
    vecs.push_back('{1'b1, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0,          1'b0, 32'h8000_0008, 1'b0, 32'h0020_0113, 32'h8000_0004});
    vecs.push_back('{1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 32'h8000_0103,  1'b0, 32'h8000_0008, 1'b0, 32'h0020_0113, 32'h8000_0004});
    vecs.push_back('{1'b0, 1'b1, 32'hDEAD_BEEF,  1'b0, 1'b0, 32'h0,          1'b1, 32'h8000_0100, 1'b0, 32'h0020_0113, 32'h8000_0004});
    vecs.push_back('{1'b1, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0,          1'b0, 32'h8000_0100, 1'b0, 32'h0020_0113, 32'h8000_0004});
    vecs.push_back('{1'b0, 1'b1, 32'h0030_0193,  1'b0, 1'b0, 32'h0,          1'b0, 32'h8000_0100, 1'b1, 32'h0030_0193, 32'h8000_0100});
    // Redirect in HOLD without inst_ready, to the top of the address space
    vecs.push_back('{1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0030_0193, 32'h8000_0100});
    vecs.push_back('{1'b1, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0,          1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0030_0193, 32'h8000_0100});
    vecs.push_back('{1'b0, 1'b1, 32'h0040_0213,  1'b1, 1'b0, 32'h0,          1'b0, 32'hFFFF_FFFC, 1'b1, 32'h0040_0213, 32'hFFFF_FFFC});
    vecs.push_back('{1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 32'h0,          1'b1, 32'h0000_0000, 1'b0, 32'h0040_0213, 32'hFFFF_FFFC});
    // Redirect in REQ while accepted
    vecs.push_back('{1'b1, 1'b0, 32'h0,          1'b0, 1'b1, 32'h8000_0200,  1'b0, 32'h0000_0000, 1'b0, 32'h0040_0213, 32'hFFFF_FFFC});
    vecs.push_back('{1'b0, 1'b1, 32'h1111_1111,  1'b0, 1'b0, 32'h0,          1'b1, 32'h8000_0200, 1'b0, 32'h0040_0213, 32'hFFFF_FFFC});
    // Redirect in REQ while not accepted: address must stay put
    vecs.push_back('{1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 32'h8000_0300,  1'b1, 32'h8000_0200, 1'b0, 32'h0040_0213, 32'hFFFF_FFFC});
    vecs.push_back('{1'b1, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0,          1'b0, 32'h8000_0200, 1'b0, 32'h0040_0213, 32'hFFFF_FFFC});
    vecs.push_back('{1'b0, 1'b1, 32'h2222_2222,  1'b0, 1'b0, 32'h0,          1'b1, 32'h8000_0300, 1'b0, 32'h0040_0213, 32'hFFFF_FFFC});
    // Redirect coincident with the response
    vecs.push_back('{1'b1, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0,          1'b0, 32'h8000_0300, 1'b0, 32'h0040_0213, 32'hFFFF_FFFC});
    vecs.push_back('{1'b0, 1'b1, 32'h3333_3333,  1'b0, 1'b1, 32'h8000_0400,  1'b1, 32'h8000_0400, 1'b0, 32'h0040_0213, 32'hFFFF_FFFC});
    // Redirect in HOLD with inst_ready
    vecs.push_back('{1'b1, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0,          1'b0, 32'h8000_0400, 1'b0, 32'h0040_0213, 32'hFFFF_FFFC});
    vecs.push_back('{1'b0, 1'b1, 32'h0050_0293,  1'b0, 1'b0, 32'h0,          1'b0, 32'h8000_0400, 1'b1, 32'h0050_0293, 32'h8000_0400});
    vecs.push_back('{1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 32'h8000_0500,  1'b1, 32'h8000_0500, 1'b0, 32'h0050_0293, 32'h8000_0400});
    // Stray response outside WAIT is ignored
    vecs.push_back('{1'b0, 1'b1, 32'h4444_4444,  1'b0, 1'b0, 32'h0,          1'b1, 32'h8000_0500, 1'b0, 32'h0050_0293, 32'h8000_0400});
    vecs.push_back('{1'b1, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0,          1'b0, 32'h8000_0500, 1'b0, 32'h0050_0293, 32'h8000_0400});
    vecs.push_back('{1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0,          1'b0, 32'h8000_0500, 1'b0, 32'h0050_0293, 32'h8000_0400});
    vecs.push_back('{1'b0, 1'b1, 32'h0060_0313,  1'b1, 1'b0, 32'h0,          1'b0, 32'h8000_0500, 1'b1, 32'h0060_0313, 32'h8000_0500});
    vecs.push_back('{1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 32'h0,          1'b1, 32'h8000_0504, 1'b0, 32'h0060_0313, 32'h8000_0500});
    vecs.push_back('{1'b1, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0,          1'b0, 32'h8000_0504, 1'b0, 32'h0060_0313, 32'h8000_0500});

    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 32'h8000_0000, 1'b0, 32'h0000_0013, 32'h8000_0000);
`ifdef YSYX_25030081_IFU_PERF_EN
    check_output("reset.perf_fetch", perf_fetch_cnt, 32'd0);
    check_output("reset.perf_stall", perf_stall_cnt, 32'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      check_all($sformatf("v%0d", i), vecs[i].e_qv, vecs[i].e_qa, vecs[i].e_iv, vecs[i].e_i, vecs[i].e_ipc);
    end

    // Reset asserted mid-WAIT takes effect without a clock edge; a late response is ignored
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check_all("midreset", 1'b0, 32'h8000_0000, 1'b0, 32'h0000_0013, 32'h8000_0000);
`ifdef YSYX_25030081_IFU_PERF_EN
    check_output("midreset.perf_fetch", perf_fetch_cnt, 32'd0);
    check_output("midreset.perf_stall", perf_stall_cnt, 32'd0);
`endif
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h5555_5555;
    @(posedge clk);
    #1;
    check_all("inreset", 1'b0, 32'h8000_0000, 1'b0, 32'h0000_0013, 32'h8000_0000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("late_resp", 1'b1, 32'h8000_0000, 1'b0, 32'h0000_0013, 32'h8000_0000);
    idle_inputs();

    // Ten zero-wait fetches with always-ready decode
    for (int f = 0; f < 10; f++) begin
      logic [31:0] a;
      logic [31:0] d;
      a = 32'h8000_0000 + 32'(f) * 32'd4;
      d = 32'h0000_0093 | (32'(f) << 20);
      imem_req_ready = 1'b1;
      @(posedge clk);
      #1;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b1;
      imem_resp_data  = d;
      inst_ready      = 1'b1;
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b0;
      check_all($sformatf("fetch%0d", f), 1'b0, a, 1'b1, d, a);
      @(posedge clk);
      #1;
      inst_ready = 1'b0;
      check_output($sformatf("fetch%0d.next_addr", f), imem_req_addr, a + 32'd4);
    end
`ifdef YSYX_25030081_IFU_PERF_EN
    check_output("perf_fetch_cnt", perf_fetch_cnt, 32'd10);
    check_output("perf_stall_cnt", perf_stall_cnt, 32'd20);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
